amp_sweep_ctrl: RTL and testbench

AMP_SWEEP_CTRL -- requirements
Module: amp_sweep_ctrl

---
 rtl/amp_sweep_pkg.sv | 21 ++
 rtl/amp_sweep_ctrl_if.sv | 29 ++
 rtl/peak_averager.sv | 42 ++++
 rtl/amp_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_amp_sweep_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/amp_sweep_pkg.sv
// Shared types and default constants for the amplitude sweep controller.
package amp_sweep_pkg;

    localparam int unsigned DefNumBands      = 8;
    localparam int unsigned DefPeaksPerBand  = 4;
    localparam int unsigned DefSettleCycles  = 1024;
    localparam int unsigned DefTimeoutCycles = 65535;

    // Band index width; covers up to 8 bands.
    localparam int unsigned BandW = 3;
    localparam int unsigned PeakW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeasure,
        StStore,
        StDone
    } sweep_state_t;

endpackage

// File: rtl/amp_sweep_ctrl_if.sv
// Control, peak-input and result signals of the sweep controller.
interface amp_sweep_ctrl_if;
    import amp_sweep_pkg::*;

    logic             start;
    logic             abort;
    logic             amplitude_vld;
    logic [PeakW-1:0] peak;
    logic [BandW-1:0] band_sel;
    logic             busy;
    logic             result_wr;
    logic [BandW-1:0] result_band;
    logic [PeakW-1:0] result_amp;
    logic             result_timeout;
    logic             done;

    // Sequencer / amplitude calculator side.
    modport master (
        output start, abort, amplitude_vld, peak,
        input  band_sel, busy, result_wr, result_band, result_amp, result_timeout, done
    );

    // Sweep controller side.
    modport slave (
        input  start, abort, amplitude_vld, peak,
        output band_sel, busy, result_wr, result_band, result_amp, result_timeout, done
    );

endinterface

// File: rtl/peak_averager.sv
// Accumulates peaks for one band and reports the average as the last peak arrives.
module peak_averager
    import amp_sweep_pkg::*;
#(
    parameter int unsigned PEAKS_PER_BAND = DefPeaksPerBand
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             vld,
    input  logic [PeakW-1:0] peak,
    output logic             full,
    output logic [PeakW-1:0] avg
);
    localparam int unsigned Shift = $clog2(PEAKS_PER_BAND);
    localparam int unsigned AccW  = PeakW + Shift;
    localparam int unsigned CntW  = $clog2(PEAKS_PER_BAND + 1);

    logic [AccW-1:0] acc;
    logic [AccW-1:0] sum;
    logic [CntW-1:0] cnt;

    // The average includes the peak arriving this cycle so the FSM can latch it on the same edge.
    assign sum  = acc + AccW'(peak);
    assign full = vld && (cnt == CntW'(PEAKS_PER_BAND - 1));
    assign avg  = sum[Shift +: PeakW];

    // Accumulator and peak count; clear has priority over a new peak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (vld) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/amp_sweep_ctrl.sv
// Steps through the equalizer bands, settles, averages peaks and writes one result per band.
module amp_sweep_ctrl
    import amp_sweep_pkg::*;
#(
    parameter int unsigned NUM_BANDS      = DefNumBands,
    parameter int unsigned PEAKS_PER_BAND = DefPeaksPerBand,
    parameter int unsigned SETTLE_CYCLES  = DefSettleCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input logic             clk,
    input logic             rst_n,
    amp_sweep_ctrl_if.slave bus
);
    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [TmoW-1:0]    TmoLast    = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [BandW-1:0]   LastBand   = BandW'(NUM_BANDS - 1);

    sweep_state_t       state;
    logic [SettleW-1:0] settle_cnt;
    logic [TmoW-1:0]    tmo_cnt;
    logic [BandW-1:0]   cur_band;
    logic               res_wr;
    logic [BandW-1:0]   res_band;
    logic [PeakW-1:0]   res_amp;
    logic               res_timeout;
    logic               done_pulse;

    logic               acc_vld;
    logic               acc_clr;
    logic               acc_full;
    logic [PeakW-1:0]   acc_avg;

    // Peaks count only in MEASURE; leaving MEASURE for any reason discards partial data.
    assign acc_vld = bus.amplitude_vld && (state == StMeasure);
    assign acc_clr = (state != StMeasure);

    peak_averager #(
        .PEAKS_PER_BAND(PEAKS_PER_BAND)
    ) u_peak_averager (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (acc_clr),
        .vld  (acc_vld),
        .peak (bus.peak),
        .full (acc_full),
        .avg  (acc_avg)
    );

    // Sweep FSM with registered result/done strobes; abort overrides every non-idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            cur_band    <= '0;
            res_wr      <= 1'b0;
            res_band    <= '0;
            res_amp     <= '0;
            res_timeout <= 1'b0;
            done_pulse  <= 1'b0;
        end else begin
            res_wr     <= 1'b0;
            done_pulse <= 1'b0;
            if (state != StIdle && bus.abort) begin
                state      <= StIdle;
                settle_cnt <= '0;
                tmo_cnt    <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (bus.start && !bus.abort) begin
                            state      <= StSettle;
                            cur_band   <= '0;
                            settle_cnt <= '0;
                            tmo_cnt    <= '0;
                        end
                    end
                    StSettle: begin
                        if (settle_cnt == SettleLast) begin
                            state      <= StMeasure;
                            settle_cnt <= '0;
                            tmo_cnt    <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    StMeasure: begin
                        // The final peak beats a timeout landing on the same cycle.
                        if (acc_full) begin
                            state       <= StStore;
                            res_wr      <= 1'b1;
                            res_band    <= cur_band;
                            res_amp     <= acc_avg;
                            res_timeout <= 1'b0;
                        end else if (tmo_cnt == TmoLast) begin
                            state       <= StStore;
                            res_wr      <= 1'b1;
                            res_band    <= cur_band;
                            res_amp     <= '0;
                            res_timeout <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    StStore: begin
                        settle_cnt <= '0;
                        tmo_cnt    <= '0;
                        if (cur_band == LastBand) begin
                            state      <= StDone;
                            done_pulse <= 1'b1;
                        end else begin
                            state    <= StSettle;
                            cur_band <= cur_band + 1'b1;
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.band_sel       = cur_band;
    assign bus.busy           = (state != StIdle);
    assign bus.result_wr      = res_wr;
    assign bus.result_band    = res_band;
    assign bus.result_amp     = res_amp;
    assign bus.result_timeout = res_timeout;
    assign bus.done           = done_pulse;

endmodule

// File: tb/tb_amp_sweep_ctrl.sv
// Directed scoreboard bench for amp_sweep_ctrl with 2 bands, 4 peaks, settle 8, timeout 32.
module tb_amp_sweep_ctrl;
    import amp_sweep_pkg::*;

    localparam int NB = 2;
    localparam int K  = 4;
    localparam int ST = 8;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst_n;

    amp_sweep_ctrl_if bus();

    amp_sweep_ctrl #(
        .NUM_BANDS     (NB),
        .PEAKS_PER_BAND(K),
        .SETTLE_CYCLES (ST),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int band;
        int amp;
        int tmo;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t mon_e;
    int   mon_d;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic settle_wait();
        repeat (ST) tick();
    endtask

    task automatic push_result(input int band, input int amp, input int tmo, input int at);
        exp_t e;
        e.band = band;
        e.amp  = amp;
        e.tmo  = tmo;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic drive_peak(input int v);
        bus.amplitude_vld = 1'b1;
        bus.peak          = 16'(v);
        tick();
        bus.amplitude_vld = 1'b0;
    endtask

    // Called on the first MEASURE cycle; four back-to-back peaks, result due K cycles later.
    task automatic run_band(input int band, input int p0, input int p1, input int p2,
                            input int p3, input int amp);
        push_result(band, amp, 0, cyc + K);
        drive_peak(p0);
        drive_peak(p1);
        drive_peak(p2);
        drive_peak(p3);
    endtask

    // Called on the STORE cycle of the last band.
    task automatic finish_sweep();
        done_q.push_back(cyc + 1);
        tick();
        check("busy in DONE", bus.busy, 1);
        tick();
        check("busy after DONE", bus.busy, 0);
        check("pending results", exp_q.size(), 0);
        check("pending done", done_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " band_sel"}, bus.band_sel, 0);
        check({tag, " result_wr"}, bus.result_wr, 0);
        check({tag, " done"}, bus.done, 0);
        check({tag, " result_timeout"}, bus.result_timeout, 0);
        check({tag, " result_band"}, bus.result_band, 0);
        check({tag, " result_amp"}, bus.result_amp, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a result or done.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.result_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected result_wr", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result_band", bus.result_band, mon_e.band);
                    check("result_amp", bus.result_amp, mon_e.amp);
                    check("result_timeout", bus.result_timeout, mon_e.tmo);
                    if (mon_e.at >= 0) check("result_wr cycle", cyc, mon_e.at);
                end
            end
            if (bus.done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("unexpected done", 1, 0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done cycle", cyc, mon_d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.amplitude_vld = 1'b0;
        bus.peak          = '0;
        rst_n             = 1'b0;
        #12;
        check_all_zero("reset");
        #10 rst_n = 1'b1;
        tick();

        // Basic two-band sweep with averaging and saturating peaks.
        pulse_start();
        check("busy after start", bus.busy, 1);
        check("band_sel after start", bus.band_sel, 0);
        settle_wait();
        run_band(0, 100, 200, 300, 400, 250);
        tick();
        settle_wait();
        check("band_sel band 1", bus.band_sel, 1);
        run_band(1, 65535, 65535, 65535, 65535, 65535);
        finish_sweep();
        check("result_amp holds", bus.result_amp, 65535);
        check("band_sel holds", bus.band_sel, 1);

        // Peaks during SETTLE, including its last cycle, must not count.
        pulse_start();
        for (int i = 0; i < ST; i++) begin
            bus.amplitude_vld = (i == 0 || i == 3 || i == ST - 1);
            bus.peak          = 16'd60000;
            tick();
        end
        bus.amplitude_vld = 1'b0;
        run_band(0, 10, 20, 30, 40, 25);
        tick();
        settle_wait();
        run_band(1, 1, 2, 3, 5, 2);
        finish_sweep();

        // Timeout on band 0, sweep continues on band 1.
        pulse_start();
        settle_wait();
        m = cyc;
        push_result(0, 0, 1, m + TO);
        repeat (TO) tick();
        tick();
        check("timeout flag holds", bus.result_timeout, 1);
        check("timeout amp holds", bus.result_amp, 0);
        check("busy after timeout", bus.busy, 1);
        check("band_sel after timeout", bus.band_sel, 1);
        settle_wait();
        run_band(1, 4, 4, 4, 4, 4);
        finish_sweep();

        // Fourth peak on the final timeout cycle wins.
        pulse_start();
        settle_wait();
        m = cyc;
        push_result(0, 2500, 0, m + TO);
        drive_peak(1000);
        drive_peak(2000);
        drive_peak(3000);
        repeat (TO - 4) tick();
        drive_peak(4000);
        tick();
        settle_wait();
        run_band(1, 8, 8, 8, 9, 8);
        finish_sweep();

        // Start together with abort in IDLE stays idle.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start+abort idle", bus.busy, 0);
        tick();
        check("start+abort still idle", bus.busy, 0);

        // Abort in band 1 MEASURE after a start issued while busy.
        pulse_start();
        settle_wait();
        run_band(0, 7, 7, 7, 7, 7);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (ST - 1) tick();
        check("band_sel ignores restart", bus.band_sel, 1);
        check("busy in band 1", bus.busy, 1);
        drive_peak(500);
        drive_peak(600);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("busy after abort", bus.busy, 0);
        repeat (TO + 8) tick();
        check("idle after abort", bus.busy, 0);
        check("pending after abort", exp_q.size(), 0);

        // Asynchronous reset during band 1 SETTLE, then a fresh sweep.
        pulse_start();
        settle_wait();
        run_band(0, 50, 50, 50, 50, 50);
        tick();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid-sweep reset");
        #3 rst_n = 1'b1;
        tick();
        pulse_start();
        check("band_sel after restart", bus.band_sel, 0);
        settle_wait();
        run_band(0, 0, 0, 0, 3, 0);
        tick();
        settle_wait();
        run_band(1, 65535, 65535, 65535, 65532, 65534);
        finish_sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
